julia_render_sched: RTL and testbench

Frame-render scheduler for the Julia-set display path. It walks every pixel of an H_RES×V_RES frame and starts the iteration engine once per pixel. It waits for the engine's completion, then issues exactly one BRAM write per pixel with the 4-bit shade. It also restarts the frame cleanly when a redraw is requested after a zoom step or constant change. It sits between the button/zoom FSM, the Julia iteration engine, and port A of the frame BRAM.

---
 rtl/julia_pkg.sv | 9 +
 rtl/julia_pixel_cnt.sv | 31 +++
 rtl/julia_render_sched.sv | 92 +++++++++
 tb/tb_julia_render_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// julia_pkg: frame defaults, scheduler states and the iteration-to-shade mapping shared with the display path
package julia_pkg;
   localparam int H_RES_DEF = 1280;
   localparam int V_RES_DEF = 720;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} sched_state_t;
   function automatic logic [3:0] shade(input logic [8:0] iter);
      return (iter >= 9'd240) ? 4'hf : iter[7:4];
   endfunction
endpackage

// File: rtl/julia_pixel_cnt.sv
// julia_pixel_cnt: raster x/y walker carrying a running linear address so no multiplier is needed
module julia_pixel_cnt
   import julia_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        step,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic [19:0] addr,
   output logic        last
);
   logic x_end;
   assign x_end = x == 11'(H_RES - 1);
   assign last = x_end && (y == 10'(V_RES - 1));
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         x <= '0;
         y <= '0;
         addr <= '0;
      end else if (step) begin
         x <= x_end ? 11'd0 : x + 11'd1;
         y <= x_end ? y + 10'd1 : y;
         addr <= addr + 20'd1;
      end
   end
endmodule

// File: rtl/julia_render_sched.sv
// julia_render_sched: walks the frame, starts the engine per pixel and writes one shade per pixel to BRAM
module julia_render_sched
   import julia_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF,
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redraw_req,
   output logic        eng_start,
   output logic [10:0] eng_x,
   output logic [9:0]  eng_y,
   input  logic        eng_done,
   input  logic [8:0]  eng_iter,
   output logic        wr_en,
   output logic [19:0] wr_addr,
   output logic [3:0]  wr_data,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  frame_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   sched_state_t state;
   logic pending, req, last, clear, step, timed_out;
   logic [TW-1:0] wait_cnt;
   // a request arriving in the same cycle it is consumed counts as already pending
   assign req = pending | redraw_req;
   assign timed_out = wait_cnt == TW'(TIMEOUT - 1);
   assign clear = req && (state == IDLE || state == WRITE);
   assign step = (state == WRITE) && !req && !last;
   assign busy = state != IDLE;
   julia_pixel_cnt #(.H_RES(H_RES), .V_RES(V_RES)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .step(step),
      .x(eng_x),
      .y(eng_y),
      .addr(wr_addr),
      .last(last)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pending <= 1'b1;
         eng_start <= 1'b0;
         wr_en <= 1'b0;
         frame_done <= 1'b0;
         wr_data <= '0;
         frame_count <= '0;
         wait_cnt <= '0;
      end else begin
         eng_start <= 1'b0;
         wr_en <= 1'b0;
         frame_done <= 1'b0;
         pending <= req;
         case (state)
            IDLE: if (req) begin
               pending <= 1'b0;
               eng_start <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: begin
               wait_cnt <= '0;
               state <= WAIT;
            end
            WAIT: if (eng_done || timed_out) begin
               wr_data <= eng_done ? shade(eng_iter) : 4'hf;
               wr_en <= 1'b1;
               state <= WRITE;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
            WRITE: if (req) begin
               pending <= 1'b0;
               eng_start <= 1'b1;
               state <= ISSUE;
            end else if (last) begin
               frame_done <= 1'b1;
               frame_count <= frame_count + 8'd1;
               state <= IDLE;
            end else begin
               eng_start <= 1'b1;
               state <= ISSUE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_julia_render_sched.sv
// tb_julia_render_sched: randomized engine model with a write scoreboard checked by an independent monitor
module tb_julia_render_sched;
   localparam int H = 4;
   localparam int V = 3;
   localparam int TO = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic redraw_req = 1'b0;
   logic eng_done = 1'b0;
   logic [8:0] eng_iter = '0;
   logic eng_start, wr_en, busy, frame_done;
   logic [10:0] eng_x;
   logic [9:0] eng_y;
   logic [19:0] wr_addr;
   logic [3:0] wr_data;
   logic [7:0] frame_count;
   typedef struct {int addr; int data;} wr_t;
   wr_t exp_q[$];
   wr_t got;
   int tests = 0, fails = 0, fd_seen = 0, fd_exp = 0, exp_fc = 0, mx = 0, my = 0;
   logic p_start = 1'b0, p_wr = 1'b0, p_fd = 1'b0;
   int sh[7] = '{0, 15, 16, 239, 240, 255, 256};

   julia_render_sched #(.H_RES(H), .V_RES(V), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .redraw_req(redraw_req),
      .eng_start(eng_start),
      .eng_x(eng_x),
      .eng_y(eng_y),
      .eng_done(eng_done),
      .eng_iter(eng_iter),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .busy(busy),
      .frame_done(frame_done),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int shade_ref(input int it);
      return it >= 240 ? 15 : it / 16;
   endfunction

   task automatic summary;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", wr_en, 0);
         end else begin
            got = exp_q.pop_front();
            check("wr_addr", wr_addr, got.addr);
            check("wr_data", wr_data, got.data);
         end
      end
      if (p_start) check("eng_start_width", eng_start, 0);
      if (p_wr) check("wr_en_width", wr_en, 0);
      if (p_fd) check("frame_done_width", frame_done, 0);
      if (frame_done) fd_seen++;
      p_start = eng_start;
      p_wr = wr_en;
      p_fd = frame_done;
   end

   task automatic wait_start(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!eng_start && n < 40);
      if (!eng_start) begin
         check("start_timeout", n, -1);
         summary();
      end
   endtask

   task automatic do_pixel(input int lat, input bit respond, input int iter, input bit rd,
                           input bit rst_wr, input int exp_n);
      int n, d;
      wr_t w;
      wait_start(n);
      redraw_req = 1'b0;
      if (exp_n > 0) check("start_delay", n, exp_n);
      check("eng_x", eng_x, mx);
      check("eng_y", eng_y, my);
      w.addr = my * H + mx;
      w.data = respond ? shade_ref(iter) : 15;
      exp_q.push_back(w);
      d = respond ? lat + 1 : TO;
      for (int k = 1; k <= d; k++) begin
         @(negedge clk);
         redraw_req = rd && k == 1;
         check("wr_early", wr_en, 0);
         if (respond && k == d) begin
            eng_done = 1'b1;
            eng_iter = 9'(iter);
         end
      end
      @(negedge clk);
      eng_done = 1'b0;
      redraw_req = 1'b0;
      check("wr_latency", wr_en, 1);
      check("x_hold", eng_x, mx);
      check("y_hold", eng_y, my);
      if (rst_wr) begin
         rst = 1'b1;
         @(negedge clk);
         check("rst_outputs", {eng_start, wr_en, frame_done, busy, eng_x, eng_y, wr_addr, wr_data, frame_count}, 0);
         rst = 1'b0;
         mx = 0;
         my = 0;
         exp_fc = 0;
      end else if (rd) begin
         mx = 0;
         my = 0;
      end else if (mx == H - 1 && my == V - 1) begin
         mx = 0;
         my = 0;
         exp_fc = (exp_fc + 1) % 256;
         fd_exp++;
         @(negedge clk);
         check("frame_done", frame_done, 1);
         check("frame_count", frame_count, exp_fc);
         check("busy_idle", busy, 0);
      end else if (mx == H - 1) begin
         mx = 0;
         my++;
      end else begin
         mx++;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {eng_start, wr_en, frame_done, busy, eng_x, eng_y, wr_addr, wr_data, frame_count}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      // first frame: reset auto-start, latency-5 first pixel, shade boundaries after it
      do_pixel(5, 1, $urandom_range(256, 0), 0, 0, 2);
      for (int i = 1; i < H * V; i++)
         do_pixel(1, 1, i <= 7 ? sh[i - 1] : $urandom_range(256, 0), 0, 0, 0);
      repeat (3) @(negedge clk);
      check("idle_after_frame", busy, 0);
      // redraw from idle, abort during WAIT at (2,1), then a full frame with one timed-out pixel
      redraw_req = 1'b1;
      do_pixel(0, 1, $urandom_range(256, 0), 0, 0, 1);
      for (int i = 1; i < 6; i++)
         do_pixel($urandom_range(3, 0), 1, $urandom_range(256, 0), 0, 0, 0);
      do_pixel(3, 1, $urandom_range(256, 0), 1, 0, 0);
      for (int i = 0; i < H * V; i++)
         do_pixel($urandom_range(3, 0), i != 2, $urandom_range(256, 0), 0, 0, 0);
      // reset while a write is on the bus, then automatic restart from (0,0)
      @(negedge clk);
      redraw_req = 1'b1;
      do_pixel(0, 1, $urandom_range(256, 0), 0, 0, 1);
      for (int i = 1; i < 4; i++)
         do_pixel($urandom_range(3, 0), 1, $urandom_range(256, 0), 0, 0, 0);
      do_pixel(2, 1, $urandom_range(256, 0), 0, 1, 0);
      do_pixel(1, 1, $urandom_range(256, 0), 0, 0, 1);
      for (int i = 0; i < 3; i++)
         do_pixel($urandom_range(3, 0), 1, $urandom_range(256, 0), 0, 0, 0);
      @(negedge clk);
      check("frame_done_total", fd_seen, fd_exp);
      check("scoreboard_empty", exp_q.size(), 0);
      summary();
   end
endmodule
